// File: rtl/inst_issue_buffer.sv
// Circular instruction queue between fetch and dual-issue decode.
// Define INST_BUF_PERF_EN to add the empty-cycle and dual-issue performance counters.
module inst_issue_buffer #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             fetch_valid1_i,
    input  logic             fetch_valid2_i,
    input  logic [31:0]      fetch_inst1_i,
    input  logic [31:0]      fetch_inst2_i,
    input  logic [31:0]      fetch_addr1_i,
    input  logic [31:0]      fetch_addr2_i,
    input  logic [32:0]      fetch_bpu_info1_i,
    input  logic [32:0]      fetch_bpu_info2_i,
    output logic             buffer_full_o,
    input  logic             issue_i,
    input  logic             issued_i,
    input  logic             ninst_in_delayslot_i,
    output logic [31:0]      inst1_o,
    output logic [31:0]      inst2_o,
    output logic [31:0]      inst1_addr_o,
    output logic [31:0]      inst2_addr_o,
    output logic [32:0]      bpu_predict_info_o,
    output logic             issue_en_o,
    output logic             is_in_delayslot_o,
`ifdef INST_BUF_PERF_EN
    output logic [31:0]      perf_empty_cycles_o,
    output logic [31:0]      perf_dual_issue_o,
`endif
    output logic [PTR_W:0]   count_o
);

    localparam int ENTRY_W = 97;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   head_p1;
    logic [PTR_W-1:0]   tail_p1;
    logic [PTR_W:0]     count;
    logic               ds_flag;
    logic [1:0]         push_num;
    logic [1:0]         pop_req;
    logic [1:0]         pop_num;
    logic [ENTRY_W-1:0] rd1;
    logic [ENTRY_W-1:0] rd2;
    logic               has_one;
    logic               has_two;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Full means fewer than two free slots, so a dual push can never overflow.
    assign buffer_full_o = (count > (PTR_W+1)'(DEPTH - 2));

    always_comb begin
        push_num = 2'd0;
        if (!buffer_full_o && fetch_valid1_i) begin
            push_num = fetch_valid2_i ? 2'd2 : 2'd1;
        end
    end

    // A dual issue with only one entry present retires just that entry.
    always_comb begin
        pop_req = issue_i ? 2'd2 : 2'd1;
        pop_num = 2'd0;
        if (issued_i) begin
            if ((PTR_W+1)'(pop_req) > count) begin
                pop_num = count[1:0];
            end else begin
                pop_num = pop_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ds_flag <= 1'b0;
        end else begin
            head  <= head + PTR_W'(pop_num);
            tail  <= tail + PTR_W'(push_num);
            count <= count + (PTR_W+1)'(push_num) - (PTR_W+1)'(pop_num);
            if (issued_i) begin
                ds_flag <= !issue_i && ninst_in_delayslot_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush_i) begin
            if (push_num != 2'd0) begin
                mem[tail] <= {fetch_inst1_i, fetch_addr1_i, fetch_bpu_info1_i};
            end
            if (push_num == 2'd2) begin
                mem[tail_p1] <= {fetch_inst2_i, fetch_addr2_i, fetch_bpu_info2_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fetch_valid1_i || !fetch_valid2_i);
        end
    end

    assign rd1     = mem[head];
    assign rd2     = mem[head_p1];
    assign has_one = (count != '0);
    assign has_two = (count > (PTR_W+1)'(1));

    // Stale storage behind head must never leak out, hence the occupancy gating.
    assign inst1_o            = has_one ? rd1[96:65] : 32'd0;
    assign inst1_addr_o       = has_one ? rd1[64:33] : 32'd0;
    assign bpu_predict_info_o = has_one ? rd1[32:0]  : 33'd0;
    assign inst2_o            = has_two ? rd2[96:65] : 32'd0;
    assign inst2_addr_o       = has_two ? rd2[64:33] : 32'd0;
    assign issue_en_o         = has_one;
    assign is_in_delayslot_o  = ds_flag && has_one;
    assign count_o            = count;

`ifdef INST_BUF_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_empty_cycles_o <= '0;
            perf_dual_issue_o   <= '0;
        end else begin
            if (!has_one && !flush_i) begin
                perf_empty_cycles_o <= perf_empty_cycles_o + 32'd1;
            end
            if (pop_num == 2'd2) begin
                perf_dual_issue_o <= perf_dual_issue_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Self-checking bench for inst_issue_buffer: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_inst_issue_buffer;

    localparam int DEPTH = 32;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [32:0] bpu;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        fetch_valid1_i;
    logic        fetch_valid2_i;
    logic [31:0] fetch_inst1_i;
    logic [31:0] fetch_inst2_i;
    logic [31:0] fetch_addr1_i;
    logic [31:0] fetch_addr2_i;
    logic [32:0] fetch_bpu_info1_i;
    logic [32:0] fetch_bpu_info2_i;
    logic        buffer_full_o;
    logic        issue_i;
    logic        issued_i;
    logic        ninst_in_delayslot_i;
    logic [31:0] inst1_o;
    logic [31:0] inst2_o;
    logic [31:0] inst1_addr_o;
    logic [31:0] inst2_addr_o;
    logic [32:0] bpu_predict_info_o;
    logic        issue_en_o;
    logic        is_in_delayslot_o;
    logic [5:0]  count_o;

    entry_t q[$];
    bit     mflag;
    int     errors = 0;
    int     checks = 0;

    inst_issue_buffer #(.DEPTH(DEPTH), .PTR_W(5)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush_i              (flush_i),
        .fetch_valid1_i       (fetch_valid1_i),
        .fetch_valid2_i       (fetch_valid2_i),
        .fetch_inst1_i        (fetch_inst1_i),
        .fetch_inst2_i        (fetch_inst2_i),
        .fetch_addr1_i        (fetch_addr1_i),
        .fetch_addr2_i        (fetch_addr2_i),
        .fetch_bpu_info1_i    (fetch_bpu_info1_i),
        .fetch_bpu_info2_i    (fetch_bpu_info2_i),
        .buffer_full_o        (buffer_full_o),
        .issue_i              (issue_i),
        .issued_i             (issued_i),
        .ninst_in_delayslot_i (ninst_in_delayslot_i),
        .inst1_o              (inst1_o),
        .inst2_o              (inst2_o),
        .inst1_addr_o         (inst1_addr_o),
        .inst2_addr_o         (inst2_addr_o),
        .bpu_predict_info_o   (bpu_predict_info_o),
        .issue_en_o           (issue_en_o),
        .is_in_delayslot_o    (is_in_delayslot_o),
        .count_o              (count_o)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setData(input logic [31:0] i1, input logic [31:0] a1,
                           input logic [31:0] i2, input logic [31:0] a2);
        fetch_inst1_i     = i1;
        fetch_addr1_i     = a1;
        fetch_inst2_i     = i2;
        fetch_addr2_i     = a2;
        fetch_bpu_info1_i = {1'b0, i1 ^ a1};
        fetch_bpu_info2_i = {1'b1, i2 ^ a2};
    endtask

    task automatic randData();
        fetch_inst1_i     = $urandom;
        fetch_addr1_i     = $urandom;
        fetch_inst2_i     = $urandom;
        fetch_addr2_i     = $urandom;
        fetch_bpu_info1_i = {1'($urandom), 32'($urandom)};
        fetch_bpu_info2_i = {1'($urandom), 32'($urandom)};
    endtask

    // Drive one cycle, advance the model by the queue rules, then compare.
    task automatic applyStimulus(input bit r, input bit f, input bit v1, input bit v2,
                                 input bit iss_dual, input bit issued, input bit nds);
        int sz;
        int pop;
        rst                  = r;
        flush_i              = f;
        fetch_valid1_i       = v1;
        fetch_valid2_i       = v2;
        issue_i              = iss_dual;
        issued_i             = issued;
        ninst_in_delayslot_i = nds;
        if (r || f) begin
            q.delete();
            mflag = 1'b0;
        end else begin
            sz  = q.size();
            pop = issued ? (iss_dual ? 2 : 1) : 0;
            if (pop > sz) pop = sz;
            if (issued) mflag = !iss_dual && nds;
            for (int k = 0; k < pop; k++) void'(q.pop_front());
            if (DEPTH - sz >= 2 && v1) begin
                q.push_back('{fetch_inst1_i, fetch_addr1_i, fetch_bpu_info1_i});
                if (v2) q.push_back('{fetch_inst2_i, fetch_addr2_i, fetch_bpu_info2_i});
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkOutput();
        int sz;
        sz = q.size();
        checkValue("count", 64'(count_o), 64'(sz));
        checkValue("full", 64'(buffer_full_o), 64'(DEPTH - sz < 2));
        checkValue("issue_en", 64'(issue_en_o), 64'(sz != 0));
        checkValue("delayslot", 64'(is_in_delayslot_o), 64'(mflag && sz != 0));
        checkValue("inst1", 64'(inst1_o), sz > 0 ? 64'(q[0].inst) : 64'd0);
        checkValue("addr1", 64'(inst1_addr_o), sz > 0 ? 64'(q[0].addr) : 64'd0);
        checkValue("bpu", 64'(bpu_predict_info_o), sz > 0 ? 64'(q[0].bpu) : 64'd0);
        checkValue("inst2", 64'(inst2_o), sz > 1 ? 64'(q[1].inst) : 64'd0);
        checkValue("addr2", 64'(inst2_addr_o), sz > 1 ? 64'(q[1].addr) : 64'd0);
    endtask

    initial begin
        bit v1;
        bit v2;
        int mode;
        setData(32'd0, 32'd0, 32'd0, 32'd0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkValue("idle_count", 64'(count_o), 64'd0);
        checkValue("idle_inst1", 64'(inst1_o), 64'd0);

        setData(32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkValue("push_inst1", 64'(inst1_o), 64'h24010001);
        checkValue("push_addr2", 64'(inst2_addr_o), 64'hBFC00004);
        checkValue("push_count", 64'(count_o), 64'd2);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkValue("dualpop_count", 64'(count_o), 64'd0);

        // Fill to 30, then 32; the extra push is dropped and two pops reopen space.
        for (int i = 0; i < 15; i++) begin
            randData();
            applyStimulus(0, 0, 1, 1, 0, 0, 0);
        end
        checkValue("fill30_full", 64'(buffer_full_o), 64'd0);
        randData();
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkValue("fill32_full", 64'(buffer_full_o), 64'd1);
        randData();
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkValue("drop_count", 64'(count_o), 64'd32);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkValue("pop31_full", 64'(buffer_full_o), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkValue("pop30_full", 64'(buffer_full_o), 64'd0);

        // Walk head to index 31, then push a pair that wraps to index 0.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 31; i++) begin
            randData();
            applyStimulus(0, 0, 1, 0, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        setData(32'hAAAA0001, 32'h0000_1000, 32'hBBBB0002, 32'h0000_1004);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkValue("wrap_inst2", 64'(inst2_o), 64'hBBBB0002);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);

        setData(32'h0C000040, 32'h100, 32'h00000000, 32'h104);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkValue("ds_flag", 64'(is_in_delayslot_o), 64'd1);
        checkValue("ds_addr", 64'(inst1_addr_o), 64'h104);
        randData();
        applyStimulus(0, 0, 1, 0, 0, 1, 0);
        checkValue("ds_clear", 64'(is_in_delayslot_o), 64'd0);

        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkValue("pre_flush_count", 64'(count_o), 64'd5);
        applyStimulus(0, 1, 1, 1, 0, 1, 1);
        checkValue("flush_count", 64'(count_o), 64'd0);
        checkValue("flush_en", 64'(issue_en_o), 64'd0);

        // Random traffic in push-heavy, pop-heavy and mixed phases.
        for (int i = 0; i < 1500; i++) begin
            mode = (i / 100) % 3;
            randData();
            v1 = (mode == 0) ? ($urandom_range(0, 9) < 8) :
                 (mode == 1) ? ($urandom_range(0, 9) < 2) : 1'($urandom);
            v2 = v1 && 1'($urandom);
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0, v1, v2,
                          1'($urandom),
                          (mode == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7),
                          1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
